// File: rtl/des_pkg.sv
// des_pkg: DES permutation tables and functions, S-boxes, key shift schedule and controller state type
package des_pkg;
  localparam int W64 = 64;
  localparam int W56 = 56;
  localparam int W48 = 48;
  localparam int W32 = 32;
  localparam int W28 = 28;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [1:0] SHIFT [0:17] = '{0, 1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1, 0};
  localparam int IP_T [0:63] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [0:63] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int E_T [0:47] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [0:31] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [0:55] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [0:47] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam logic [3:0] SBOX [0:7][0:63] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};
  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
    return y;
  endfunction
  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
    return y;
  endfunction
  function automatic logic [47:0] ebox(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_T[6'(i)])];
    return y;
  endfunction
  function automatic logic [31:0] pbox(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_T[5'(i)])];
    return y;
  endfunction
  function automatic logic [55:0] pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_T[6'(i)])];
    return y;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_T[6'(i)])];
    return y;
  endfunction
  function automatic logic [3:0] sbox(input logic [2:0] n, input logic [5:0] b);
    return SBOX[n][{b[5], b[0], b[4:1]}];
  endfunction
  function automatic logic [27:0] rot28(input logic [27:0] x, input logic [1:0] n, input logic right);
    logic [55:0] t;
    t = right ? ({x, x} >> n) : ({x, x} << n);
    return right ? t[27:0] : t[55:28];
  endfunction
endpackage

// File: rtl/des_f.sv
// des_f: combinational DES f-function P(S1..S8(E(r) ^ k))
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);
  logic [47:0] x;
  logic [31:0] s;
  assign x = ebox(r) ^ k;
  for (genvar i = 0; i < 8; i++) begin : g_sbox
    assign s[31 - 4*i -: 4] = sbox(3'(i), x[47 - 6*i -: 6]);
  end
  assign f = pbox(s);
endmodule

// File: rtl/des_iter_ctrl.sv
// des_iter_ctrl: iterative DES controller running one round per clock over a shared f-function
module des_iter_ctrl
  import des_pkg::*;
#(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_decrypt,
  input  logic [63:0] in_key,
  input  logic [63:0] in_block,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy
);
  state_t      state;
  logic [4:0]  rnd;
  logic [31:0] l, r, f;
  logic [27:0] c, d, c_n, d_n;
  logic        dec;
  logic [1:0]  sh;
  logic [47:0] k;
  always_comb begin
    sh  = dec ? SHIFT[5'd18 - rnd] : SHIFT[rnd];
    c_n = rot28(c, sh, dec);
    d_n = rot28(d, sh, dec);
    k   = pc2({c_n, d_n});
  end
  des_f u_f (.r(r), .k(k), .f(f));
  assign out_block = fp({r, l});
  always_ff @(posedge clk)
    if (!rst_n) begin
      state     <= IDLE;
      rnd       <= '0;
      l         <= '0;
      r         <= '0;
      c         <= '0;
      d         <= '0;
      dec       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else
      case (state)
        IDLE:
          if (in_valid) begin
            {l, r}   <= ip(in_block);
            {c, d}   <= pc1(in_key);
            dec      <= in_decrypt;
            rnd      <= 5'd1;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        RUN: begin
          l   <= r;
          r   <= l ^ f;
          c   <= c_n;
          d   <= d_n;
          rnd <= rnd + 5'd1;
          if (rnd == 5'(ROUNDS)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE:
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        default: state <= IDLE;
      endcase
endmodule
